// File: rtl/fifo_rd_fwft_adapter.sv
// rtl/fifo_rd_fwft_adapter.sv - first-word-fall-through valid/ready adapter for a 1-cycle-latency FIFO read port
//
// Purpose:
//   Issues reads to an upstream FIFO whose read data appears one cycle after
//   an accepted read. It collects the returned words in a small prefetch
//   buffer and presents the oldest word as a valid/ready stream. The read
//   enable depends only on local occupancy. It never looks at i_ready, so the
//   consumer handshake has no combinational path into the FIFO.
//
// Ports:
//   i_clk         read-domain clock, rising edge
//   i_rst         synchronous active-high reset; also gates all outputs low
//   i_fifo_empty  FIFO empty flag
//   i_fifo_data   FIFO read data, valid the cycle after o_fifo_ren
//   o_fifo_ren    FIFO read enable
//   o_valid       head word present on o_data
//   o_data        head word
//   i_ready       consumer accepts the head word this cycle
//   i_flush       drop all buffered and in-flight words
//   o_level       number of buffered words
module fifo_rd_fwft_adapter #(
  parameter int g_width     = 8,
  parameter int g_buf_depth = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_fifo_empty,
  input  logic [g_width-1:0]                 i_fifo_data,
  output logic                               o_fifo_ren,
  output logic                               o_valid,
  output logic [g_width-1:0]                 o_data,
  input  logic                               i_ready,
  input  logic                               i_flush,
  output logic [$clog2(g_buf_depth+1)-1:0]   o_level
);

  localparam int c_lvl_w = $clog2(g_buf_depth + 1);
  localparam int c_ptr_w = $clog2(g_buf_depth);

  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(g_buf_depth - 1);
  // One bit wider than level so that level + inflight cannot wrap.
  localparam logic [c_lvl_w:0]   c_depth    = (c_lvl_w + 1)'(g_buf_depth);

  logic [g_width-1:0] buf_q [g_buf_depth];
  logic [c_ptr_w-1:0] rd_ptr;
  logic [c_ptr_w-1:0] wr_ptr;
  logic [c_lvl_w-1:0] level;
  logic               inflight_q;
  logic               push;
  logic               pop;
  logic [c_lvl_w:0]   committed;

  // Depth need not be a power of two, so wrap by compare-and-clear.
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
  endfunction

  // Slots already spoken for: stored words plus the word still on its way
  // back from the FIFO. A read is issued only if that word has room.
  assign committed  = {1'b0, level} + {{c_lvl_w{1'b0}}, inflight_q};
  assign o_fifo_ren = !i_rst && !i_flush && !i_fifo_empty && (committed < c_depth);

  assign o_valid = !i_rst && (level != '0);
  assign o_data  = i_rst ? '0 : buf_q[rd_ptr];
  assign o_level = i_rst ? '0 : level;

  // The word returning during a flush is discarded.
  assign push = inflight_q && !i_flush;
  assign pop  = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < g_buf_depth; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      inflight_q <= o_fifo_ren;
      if (i_flush) begin
        level  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          buf_q[wr_ptr] <= i_fifo_data;
          wr_ptr        <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (push && !pop) begin
          level <= level + c_lvl_w'(1);
        end else if (!push && pop) begin
          level <= level - c_lvl_w'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_fwft_adapter.sv
// tb/tb_fifo_rd_fwft_adapter.sv - randomized self-checking bench for fifo_rd_fwft_adapter
module tb_fifo_rd_fwft_adapter;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_ren;
  logic         valid;
  logic [W-1:0] data;
  logic         ready;
  logic         flush;
  logic [1:0]   level;

  always #5 clk = ~clk;

  fifo_rd_fwft_adapter #(.g_width(W), .g_buf_depth(D)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_ren   (fifo_ren),
    .o_valid      (valid),
    .o_data       (data),
    .i_ready      (ready),
    .i_flush      (flush),
    .o_level      (level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream FIFO contents and the words the adapter should currently hold.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] m_q[$];
  bit           m_inflight;
  bit           m_fresh;
  int           m_pops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, then
  // play the FIFO's part at the rising edge.
  task automatic cycle();
    bit exp_ren, exp_valid, push, pop, rd_now;
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    exp_valid = !rst && (m_q.size() != 0);
    exp_ren   = !rst && !flush && !fifo_empty && ((m_q.size() + int'(m_inflight)) < D);
    check("fifo_ren", 32'(fifo_ren), 32'(exp_ren));
    check("valid", 32'(valid), 32'(exp_valid));
    check("level", 32'(level), rst ? 32'd0 : 32'(m_q.size()));
    if (rst || m_fresh) check("data_zero", 32'(data), 32'd0);
    else if (exp_valid) check("data_head", 32'(data), 32'(m_q[0]));

    pop  = exp_valid && ready;
    push = m_inflight && !flush && !rst;
    if (rst) begin
      m_q.delete();
      m_fresh = 1'b1;
    end else if (flush) begin
      m_q.delete();
    end else begin
      if (push) begin
        check("no_overflow", 32'(m_q.size() < D), 32'd1);
      end
      if (pop) begin
        void'(m_q.pop_front());
        m_pops++;
      end
      if (push) begin
        m_q.push_back(fifo_data);
        m_fresh = 1'b0;
      end
    end
    m_inflight = exp_ren;
    rd_now = fifo_ren && !fifo_empty;

    @(posedge clk);
    #1;
    if (rd_now) fifo_data = fifo_q.pop_front();
    else        fifo_data = W'($urandom);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((fifo_q.size() != 0 || m_q.size() != 0 || m_inflight) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (n >= max_cycles) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!valid && n < max_cycles) begin
      cycle();
      n++;
    end
  endtask

  logic [W-1:0] src[$];
  int           n;

  initial begin
    rst = 1'b1; flush = 1'b0; ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0;
    m_inflight = 1'b0; m_fresh = 1'b1; m_pops = 0;

    repeat (2) cycle();
    rst = 1'b0;

    // Idle with an empty FIFO.
    repeat (10) cycle();

    // Three words, consumer always ready.
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    ready = 1'b1; m_pops = 0;
    repeat (8) cycle();
    check("t2_pops", 32'(m_pops), 32'd3);

    // Consumer stalled: only the buffer depth is fetched, then drain.
    ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(W'(8'hA0 + i));
    repeat (6) cycle();
    check("t3_reads", 32'(fifo_q.size()), 32'd5);
    check("t3_level", 32'(level), 32'd3);
    check("t3_head", 32'(data), 32'hA0);
    ready = 1'b1; m_pops = 0;
    repeat (14) cycle();
    check("t3_pops", 32'(m_pops), 32'd8);

    // Random fill, ready toggling every cycle.
    for (int i = 0; i < 50; i++) src.push_back(W'($urandom));
    m_pops = 0; ready = 1'b0; n = 0;
    while ((src.size() != 0 || fifo_q.size() != 0 || m_q.size() != 0 || m_inflight) && n < 2000) begin
      if (src.size() != 0 && $urandom_range(1, 0) == 1) begin
        fifo_q.push_back(src.pop_front());
        if (src.size() != 0 && $urandom_range(1, 0) == 1) fifo_q.push_back(src.pop_front());
      end
      ready = ~ready;
      cycle();
      n++;
    end
    if (n >= 2000) check("t4_timeout", 32'd0, 32'd1);
    check("t4_pops", 32'(m_pops), 32'd50);

    // Flush with two words buffered and one in flight.
    ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(W'(8'hC0 + i));
    n = 0;
    while (!(m_q.size() == 2 && m_inflight) && n < 20) begin
      cycle();
      n++;
    end
    check("t5_setup", 32'(m_q.size() == 2 && m_inflight), 32'd1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("t5_valid_after", 32'(valid), 32'd0);
    check("t5_level_after", 32'(level), 32'd0);
    ready = 1'b1;
    wait_valid(10);
    check("t5_next_word", 32'(data), 32'hC3);
    drain(30);

    // Reset in the middle of a stream with the buffer full.
    ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(W'(8'hD0 + i));
    n = 0;
    while (m_q.size() != 3 && n < 20) begin
      cycle();
      n++;
    end
    check("t6_full", 32'(level), 32'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_valid_after", 32'(valid), 32'd0);
    check("t6_data_after", 32'(data), 32'd0);
    check("t6_level_after", 32'(level), 32'd0);
    ready = 1'b1;
    wait_valid(10);
    check("t6_resume_word", 32'(data), 32'hD3);
    drain(30);

    check("final_level", 32'(level), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
